// File: rtl/tt_chk_pkg.sv
// Shared types and sizing helpers for the counter stream checker.
package tt_chk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } chk_state_t;

   // Width of the good/bad run counters: must hold the larger of the two thresholds.
   function automatic int run_w(input int lock_cnt, input int unlock_cnt);
      int m;
      m = (lock_cnt > unlock_cnt) ? lock_cnt : unlock_cnt;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tt_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment in
// the same cycle leave the value at one.
module tt_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= inc ? W'(1) : '0;
      end else if (inc && (value != '1)) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/tt_counter_stream_checker.sv
// Receive-side checker for a free-running counter stream: locks on, then flags
// every sample that is not previous+STEP. Optional wrap statistics: TT_CHK_WRAP_STATS_EN.
//
// state   | meaning
// IDLE    | no sample seen since reset; next accepted sample only seeds expected
// ACQUIRE | counting consecutive matches towards LOCK_CNT
// LOCKED  | tracking; mismatches are reported, UNLOCK_CNT in a row drop to ACQUIRE
module tt_counter_stream_checker
   import tt_chk_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int STEP       = 1,
   parameter int LOCK_CNT   = 2,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample_data,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
`ifdef TT_CHK_WRAP_STATS_EN
   ,
   output logic [ERR_W-1:0] wrap_count
`endif
);

   localparam int RUN_W = run_w(LOCK_CNT, UNLOCK_CNT);
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

   chk_state_t       state_q, state_d;
   logic [RUN_W-1:0] good_q, good_d;
   logic [RUN_W-1:0] bad_q, bad_d;
   logic             accept;
   logic             match;
   logic             err_hit;

   assign accept = en && sample_valid;
   assign match  = (sample_data == expected);
   assign locked = (state_q == LOCKED);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_hit = 1'b0;
      if (accept) begin
         case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
               good_d  = '0;
               bad_d   = '0;
            end
            ACQUIRE: begin
               if (!match) begin
                  good_d = '0;
               end else if (good_q == RUN_W'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  bad_d   = '0;
               end else begin
                  good_d = good_q + RUN_W'(1);
               end
            end
            LOCKED: begin
               if (match) begin
                  bad_d = '0;
               end else begin
                  err_hit = 1'b1;
                  if (bad_q == RUN_W'(UNLOCK_CNT - 1)) begin
                     state_d = ACQUIRE;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + RUN_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         good_q     <= '0;
         bad_q      <= '0;
         expected   <= '0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         err_pulse <= err_hit;
         // Clear takes effect before a coincident error sets sticky again.
         err_sticky <= err_hit || (err_sticky && !clr_err);
         if (accept) begin
            expected <= sample_data + STEP_V;
         end
      end
   end

   tt_sat_counter #(.W(ERR_W)) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_hit),
      .clr   (clr_err),
      .value (err_count)
   );

`ifdef TT_CHK_WRAP_STATS_EN
   logic             wrap_hit;
   logic [WIDTH-1:0] prev_sample;

   // In LOCKED, expected always holds previous sample + STEP.
   assign prev_sample = expected - STEP_V;
   assign wrap_hit    = accept && (state_q == LOCKED) && match && (sample_data < prev_sample);

   tt_sat_counter #(.W(ERR_W)) u_wrap_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (wrap_hit),
      .clr   (1'b0),
      .value (wrap_count)
   );
`endif

endmodule
